leo_sprite_fetch: RTL and testbench

Per-pixel sprite fetch stage for the Leo character, sitting directly upstream of the Leo palette lookup. It takes the VGA scan position plus Leo's position, facing and walk state, and addresses the Leo sprite ROM (synchronous, 1-cycle read). It emits a 4-bit palette index with an opaque flag, and the scan coordinates delayed to match. A vsync-driven animation counter selects the walk frame, and sprite state is latched once per frame so the sprite never tears.

---
 rtl/leo_sprite_pkg.sv | 25 ++
 rtl/leo_anim_ctrl.sv | 68 ++++++
 rtl/leo_sprite_fetch.sv | 107 ++++++++++
 tb/tb_leo_sprite_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/leo_sprite_pkg.sv
// leo_sprite_pkg
//   Shared defaults and helpers for the Leo sprite fetch stage.
//   - DEF_* : default sprite geometry, animation and transparency settings
//   - addr_w: ROM address width for a given frame count and sprite size
//   - cnt_w : counter width that never collapses to zero bits
//   - anim_frame_t: walk-frame index at the default frame count
package leo_sprite_pkg;

    localparam int         DEF_SPR_W      = 16;
    localparam int         DEF_SPR_H      = 32;
    localparam int         DEF_FRAMES     = 3;
    localparam int         DEF_FRAME_DIV  = 6;
    localparam logic [3:0] DEF_TRANSP_IDX = 4'd0;

    function automatic int addr_w(input int frames, input int w, input int h);
        return $clog2(frames * w * h);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(DEF_FRAMES)-1:0] anim_frame_t;

endpackage

// File: rtl/leo_anim_ctrl.sv
// leo_anim_ctrl
//   Frame-start detection and per-frame sprite state.
//   Ports:
//     Clk, Reset          : pixel clock, synchronous active-high reset
//     vs                  : VGA vsync (active low); its falling edge is frame start
//     sprite_x/y          : live Leo top-left position
//     facing_left,walking : live Leo facing / walk state
//     lat_x/lat_y         : position latched at frame start
//     lat_facing          : facing latched at frame start
//     frame               : current walk animation frame
import leo_sprite_pkg::*;

module leo_anim_ctrl #(
    parameter int FRAMES    = DEF_FRAMES,
    parameter int FRAME_DIV = DEF_FRAME_DIV,
    parameter int FRM_W     = cnt_w(DEF_FRAMES)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             vs,
    input  logic [9:0]       sprite_x,
    input  logic [9:0]       sprite_y,
    input  logic             facing_left,
    input  logic             walking,
    output logic [9:0]       lat_x,
    output logic [9:0]       lat_y,
    output logic             lat_facing,
    output logic [FRM_W-1:0] frame
);

    localparam int DIV_W = cnt_w(FRAME_DIV);

    logic             vs_q;
    logic             fs;
    logic [DIV_W-1:0] div;

    // vs_q resets high so a vs already low out of reset is not a frame start
    assign fs = vs_q & ~vs;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_q       <= 1'b1;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_facing <= 1'b0;
            frame      <= '0;
            div        <= '0;
        end else begin
            vs_q <= vs;
            if (fs) begin
                lat_x      <= sprite_x;
                lat_y      <= sprite_y;
                lat_facing <= facing_left;
                if (!walking) begin
                    // standing pose; restart the cadence for the next walk
                    div   <= '0;
                    frame <= '0;
                end else if (div == DIV_W'(FRAME_DIV - 1)) begin
                    div   <= '0;
                    frame <= (frame == FRM_W'(FRAMES - 1)) ? '0 : frame + FRM_W'(1);
                end else begin
                    div <= div + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/leo_sprite_fetch.sv
// leo_sprite_fetch
//   Per-pixel Leo sprite fetch. Hit-tests the scan position against the
//   frame-latched sprite box, addresses the external synchronous ROM, and
//   returns a palette index with the scan coordinates aligned to it.
//   Fixed latency of 2 cycles, no stalls.
//   Ports:
//     Clk, Reset        : pixel clock, synchronous active-high reset
//     DrawX/DrawY       : scan position, pix_valid marks the visible region
//     vs                : VGA vsync, active low
//     sprite_x/sprite_y : live Leo top-left; facing_left, walking: live state
//     rom_addr / rom_q  : sprite ROM address (registered) / data one cycle later
//     pal_index         : palette index (TRANSP_IDX outside the sprite)
//     pix_opaque        : pixel inside sprite and not transparent
//     DrawX_d/DrawY_d   : scan position aligned with pal_index
import leo_sprite_pkg::*;

module leo_sprite_fetch #(
    parameter int         SPR_W      = DEF_SPR_W,
    parameter int         SPR_H      = DEF_SPR_H,
    parameter int         FRAMES     = DEF_FRAMES,
    parameter int         FRAME_DIV  = DEF_FRAME_DIV,
    parameter logic [3:0] TRANSP_IDX = DEF_TRANSP_IDX,
    parameter int         ADDR_W     = addr_w(FRAMES, SPR_W, SPR_H)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pix_valid,
    input  logic              vs,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              facing_left,
    input  logic              walking,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        pal_index,
    output logic              pix_opaque,
    output logic [9:0]        DrawX_d,
    output logic [9:0]        DrawY_d
);

    localparam int FRM_W = cnt_w(FRAMES);

    logic [9:0]        lat_x, lat_y;
    logic              lat_facing;
    logic [FRM_W-1:0]  frame;

    logic [10:0]       dx, dy, col;
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic [2:1]        vld_pipe;   // hit flag per stage; stage 0 is combinational
    logic [9:0]        x_d1, y_d1;

    leo_anim_ctrl #(
        .FRAMES    (FRAMES),
        .FRAME_DIV (FRAME_DIV),
        .FRM_W     (FRM_W)
    ) u_anim (
        .Clk         (Clk),
        .Reset       (Reset),
        .vs          (vs),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .facing_left (facing_left),
        .walking     (walking),
        .lat_x       (lat_x),
        .lat_y       (lat_y),
        .lat_facing  (lat_facing),
        .frame       (frame)
    );

    // Stage 0: 11-bit differences so a scan position left of / above the
    // sprite shows up as a set sign bit rather than wrapping into range.
    always_comb begin
        dx   = {1'b0, DrawX} - {1'b0, lat_x};
        dy   = {1'b0, DrawY} - {1'b0, lat_y};
        hit  = pix_valid & ~dx[10] & (32'(dx) < SPR_W) & ~dy[10] & (32'(dy) < SPR_H);
        col  = lat_facing ? (11'(SPR_W - 1) - dx) : dx;
        addr = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
             + ADDR_W'(dy) * ADDR_W'(SPR_W)
             + ADDR_W'(col);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr <= '0;
            vld_pipe <= '0;
            x_d1     <= '0;
            y_d1     <= '0;
            DrawX_d  <= '0;
            DrawY_d  <= '0;
        end else begin
            // misses drive address 0 so the ROM port is deterministic
            rom_addr <= hit ? addr : '0;
            vld_pipe <= {vld_pipe[1], hit};
            x_d1     <= DrawX;
            y_d1     <= DrawY;
            DrawX_d  <= x_d1;
            DrawY_d  <= y_d1;
        end
    end

    assign pal_index  = vld_pipe[2] ? rom_q : TRANSP_IDX;
    assign pix_opaque = vld_pipe[2] & (rom_q != TRANSP_IDX);

endmodule

// File: tb/tb_leo_sprite_fetch.sv
module tb_leo_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        pix_valid;
    logic        vs;
    logic [9:0]  sprite_x, sprite_y;
    logic        facing_left, walking;
    logic [10:0] rom_addr;
    logic [3:0]  rom_q;
    logic [3:0]  pal_index;
    logic        pix_opaque;
    logic [9:0]  DrawX_d, DrawY_d;

    logic [3:0]  rom [0:2047];
    int          n_pass = 0;
    int          n_tot  = 0;

    always #5 Clk = ~Clk;

    // external synchronous ROM, one-cycle read
    always @(posedge Clk) rom_q <= rom[rom_addr];

    leo_sprite_fetch dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pix_valid   (pix_valid),
        .vs          (vs),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .facing_left (facing_left),
        .walking     (walking),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .pal_index   (pal_index),
        .pix_opaque  (pix_opaque),
        .DrawX_d     (DrawX_d),
        .DrawY_d     (DrawY_d)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // one vsync low pulse: frame start is taken on the first edge
    task automatic vs_pulse();
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
    endtask

    task automatic pix(input int x, input int y, input logic v);
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        pix_valid = v;
    endtask

    task automatic test_reset();
        Reset = 1'b1; vs = 1'b1; walking = 1'b0; facing_left = 1'b0;
        sprite_x = 10'd100; sprite_y = 10'd200;
        pix(103, 205, 1'b1);
        tick(); tick();
        n_tot++; if (rom_addr !== 11'd0) $display("FAIL reset_addr got %0d want 0", rom_addr); else n_pass++;
        n_tot++; if (pal_index !== 4'd0) $display("FAIL reset_pal got %0d want 0", pal_index); else n_pass++;
        n_tot++; if (pix_opaque !== 1'b0) $display("FAIL reset_opaque got %0b want 0", pix_opaque); else n_pass++;
        n_tot++; if (DrawX_d !== 10'd0 || DrawY_d !== 10'd0)
            $display("FAIL reset_xy got %0d,%0d want 0,0", DrawX_d, DrawY_d); else n_pass++;
        Reset = 1'b0;
        pix_valid = 1'b0;
        vs_pulse();
        // mid-line reset with a pixel over the sprite
        pix(103, 205, 1'b1);
        tick(); tick();
        n_tot++; if (pix_opaque !== 1'b1) $display("FAIL preRst_opaque got %0b want 1", pix_opaque); else n_pass++;
        Reset = 1'b1;
        tick();
        n_tot++; if (pal_index !== 4'd0 || pix_opaque !== 1'b0 || rom_addr !== 11'd0)
            $display("FAIL midRst_out got pal=%0d op=%0b addr=%0d want 0,0,0", pal_index, pix_opaque, rom_addr);
        else n_pass++;
        Reset = 1'b0;
        tick(); tick();
        n_tot++; if (pal_index !== 4'd0 || pix_opaque !== 1'b0)
            $display("FAIL postRst_out got pal=%0d op=%0b want 0,0", pal_index, pix_opaque); else n_pass++;
        // latched position and frame are back to 0
        pix(1, 0, 1'b1);
        tick();
        n_tot++; if (rom_addr !== 11'd1) $display("FAIL postRst_frame0 got %0d want 1", rom_addr); else n_pass++;
        pix_valid = 1'b0;
        tick();
    endtask

    task automatic test_addr();
        sprite_x = 10'd100; sprite_y = 10'd200; facing_left = 1'b0; walking = 1'b0;
        vs_pulse();
        pix(103, 205, 1'b1);
        tick();
        n_tot++; if (rom_addr !== 11'd83) $display("FAIL addr_fwd got %0d want 83", rom_addr); else n_pass++;
        pix_valid = 1'b0;
        tick();
        n_tot++; if (pal_index !== 4'd9 || pix_opaque !== 1'b1)
            $display("FAIL pal_fwd got %0d/%0b want 9/1", pal_index, pix_opaque); else n_pass++;
        n_tot++; if (DrawX_d !== 10'd103 || DrawY_d !== 10'd205)
            $display("FAIL xy_d got %0d,%0d want 103,205", DrawX_d, DrawY_d); else n_pass++;
    endtask

    task automatic test_mirror();
        facing_left = 1'b1;
        vs_pulse();
        pix(103, 205, 1'b1);
        tick();
        n_tot++; if (rom_addr !== 11'd92) $display("FAIL addr_mirror got %0d want 92", rom_addr); else n_pass++;
        pix_valid = 1'b0;
        tick();
        n_tot++; if (pal_index !== 4'd3) $display("FAIL pal_mirror got %0d want 3", pal_index); else n_pass++;
        facing_left = 1'b0;
        vs_pulse();
    endtask

    task automatic test_anim();
        logic [10:0] exp_a;
        walking = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            vs_pulse();
            pix(103, 205, 1'b1);
            tick();
            pix_valid = 1'b0;
            exp_a = 11'(((n / 6) % 3) * 512 + 83);
            n_tot++; if (rom_addr !== exp_a)
                $display("FAIL anim_fs%0d got %0d want %0d", n, rom_addr, exp_a); else n_pass++;
        end
        // frame is 1 now; dropping walking only takes effect at next fs
        walking = 1'b0;
        pix(103, 205, 1'b1);
        tick();
        pix_valid = 1'b0;
        n_tot++; if (rom_addr !== 11'd595) $display("FAIL anim_hold got %0d want 595", rom_addr); else n_pass++;
        vs_pulse();
        pix(103, 205, 1'b1);
        tick();
        pix_valid = 1'b0;
        n_tot++; if (rom_addr !== 11'd83) $display("FAIL anim_stand got %0d want 83", rom_addr); else n_pass++;
    endtask

    task automatic test_edge();
        logic        in;
        logic [10:0] exp_a;
        sprite_x = 10'd630; sprite_y = 10'd200;
        vs_pulse();
        for (int x = 629; x <= 640; x++) begin
            in    = (x >= 630 && x <= 639);
            exp_a = in ? 11'(80 + x - 630) : 11'd0;
            pix(x, 205, x != 640);
            tick();
            pix_valid = 1'b0;
            n_tot++; if (rom_addr !== exp_a)
                $display("FAIL edge_addr x=%0d got %0d want %0d", x, rom_addr, exp_a); else n_pass++;
            tick();
            n_tot++; if (pix_opaque !== in || pal_index !== (in ? rom[exp_a] : 4'd0))
                $display("FAIL edge_pix x=%0d got %0d/%0b want %0d/%0b", x, pal_index, pix_opaque,
                         in ? rom[exp_a] : 4'd0, in); else n_pass++;
        end
    endtask

    task automatic test_transp();
        sprite_x = 10'd100; sprite_y = 10'd200;
        vs_pulse();
        rom[83] = 4'd0;
        pix(103, 205, 1'b1);
        tick();
        pix_valid = 1'b0;
        tick();
        n_tot++; if (pal_index !== 4'd0 || pix_opaque !== 1'b0)
            $display("FAIL transp got %0d/%0b want 0/0", pal_index, pix_opaque); else n_pass++;
        rom[83] = 4'd9;
        // live position change is ignored until the next frame start
        sprite_x = 10'd0;
        pix(103, 205, 1'b1);
        tick();
        pix_valid = 1'b0;
        n_tot++; if (rom_addr !== 11'd83) $display("FAIL latch_hold got %0d want 83", rom_addr); else n_pass++;
        vs_pulse();
        pix(103, 205, 1'b1);
        tick();
        n_tot++; if (rom_addr !== 11'd0) $display("FAIL latch_old got %0d want 0", rom_addr); else n_pass++;
        pix(3, 205, 1'b1);
        tick();
        pix_valid = 1'b0;
        n_tot++; if (rom_addr !== 11'd83) $display("FAIL latch_new got %0d want 83", rom_addr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        sprite_x = 10'd100; sprite_y = 10'd200;
        vs_pulse();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) pix(100 + i, 200, 1'b1);
            else        pix_valid = 1'b0;
            tick();
            if (i < 16) begin
                n_tot++; if (rom_addr !== 11'(i))
                    $display("FAIL b2b_addr i=%0d got %0d want %0d", i, rom_addr, i); else n_pass++;
            end
            if (i >= 1) begin
                n_tot++; if (pal_index !== rom[i-1] || DrawX_d !== 10'(99 + i))
                    $display("FAIL b2b_pix i=%0d got %0d@%0d want %0d@%0d", i, pal_index, DrawX_d,
                             rom[i-1], 99 + i); else n_pass++;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) rom[a] = 4'((a % 15) + 1);
        test_reset();
        test_addr();
        test_mirror();
        test_anim();
        test_edge();
        test_transp();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
